// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : button_conditioner
//  Purpose  : Per-button 2-flop synchronizer, debouncer and edge/hold event
//             generator. Turns raw asynchronous push-button levels into clean
//             debounced levels plus single-cycle press, release and long-hold
//             pulses. Channels are fully independent of each other.
//  Revision : 1.0 - initial release
// ============================================================================
module button_conditioner #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 50000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_hold
);

  // One extra bit over the terminal count so the counter never needs to wrap.
  localparam int                DCNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic              s1_q;
    logic              s2_q;
    logic              stable_q,  stable_d;
    logic              press_q,   press_d;
    logic              release_q, release_d;
    logic [DCNT_W-1:0] dcnt_q,    dcnt_d;

    // Debounce: a new synchronized level must persist DEBOUNCE_CYCLES cycles;
    // any return to the stable level restarts the window from zero.
    always_comb begin
      stable_d  = stable_q;
      dcnt_d    = dcnt_q + DCNT_W'(1);
      press_d   = 1'b0;
      release_d = 1'b0;
      if (s2_q == stable_q) begin
        dcnt_d = '0;
      end else if (dcnt_q == DCNT_LAST) begin
        stable_d  = s2_q;
        dcnt_d    = '0;
        press_d   = s2_q;
        release_d = ~s2_q;
      end
    end

    // Synchronizer, debounced level and edge pulse registers.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s1_q      <= 1'b0;
        s2_q      <= 1'b0;
        stable_q  <= 1'b0;
        dcnt_q    <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        s1_q      <= btn_raw[i];
        s2_q      <= s1_q;
        stable_q  <= stable_d;
        dcnt_q    <= dcnt_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    assign btn_level[i]   = stable_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;

    if (HOLD_CYCLES > 0) begin : g_hold
      localparam int                HCNT_W    = $clog2(HOLD_CYCLES) + 1;
      localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(HOLD_CYCLES - 1);

      logic [HCNT_W-1:0] hcnt_q,      hcnt_d;
      logic              hold_done_q, hold_done_d;
      logic              hold_q,      hold_d;

      // Hold: count cycles of debounced press, fire once, then park until the
      // level drops. The cycle stable rises it is still 0, so the "not pressed"
      // branch also provides the clear on the rising edge.
      always_comb begin
        hcnt_d      = hcnt_q;
        hold_done_d = hold_done_q;
        hold_d      = 1'b0;
        if (!stable_q) begin
          hcnt_d      = '0;
          hold_done_d = 1'b0;
        end else if (!hold_done_q) begin
          if (hcnt_q == HCNT_LAST) begin
            hold_d      = 1'b1;
            hold_done_d = 1'b1;
          end else begin
            hcnt_d = hcnt_q + HCNT_W'(1);
          end
        end
      end

      // Hold counter, fired flag and hold pulse registers.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          hcnt_q      <= '0;
          hold_done_q <= 1'b0;
          hold_q      <= 1'b0;
        end else begin
          hcnt_q      <= hcnt_d;
          hold_done_q <= hold_done_d;
          hold_q      <= hold_d;
        end
      end

      assign btn_hold[i] = hold_q;
    end else begin : g_no_hold
      assign btn_hold[i] = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_button_conditioner
//  Purpose  : Directed self-checking bench for button_conditioner with
//             DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, N_BTN=5.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

  localparam int N = 5;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic [N-1:0] btn_hold;

  int checks;
  int errors;

  button_conditioner #(
    .N_BTN          (5),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (10)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_hold   (btn_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge k: inputs for edge k are applied 1 time unit after edge k-1, and the
  // outputs are sampled 1 time unit after edge k.

  task automatic test_reset();
    logic [19:0] exp;
    logic [19:0] got;
    rst_n   = 1'b0;
    btn_raw = 5'b11111;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      got = {btn_level, btn_press, btn_release, btn_hold};
      checks++;
      if (got !== 20'h0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got=%h exp=00000", k, got);
      end
    end
    // Button held through reset is seen as a fresh press after reset.
    rst_n = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      btn_raw = (k <= 20) ? 5'b11111 : 5'b00000;
      @(posedge clk); #1;
      exp = {((k >= 6 && k <= 25) ? 5'b11111 : 5'b00000),
             ((k == 6)  ? 5'b11111 : 5'b00000),
             ((k == 26) ? 5'b11111 : 5'b00000),
             ((k == 16) ? 5'b11111 : 5'b00000)};
      got = {btn_level, btn_press, btn_release, btn_hold};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_holdoff edge=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [19:0] exp;
    logic [19:0] got;
    for (int k = 1; k <= 40; k++) begin
      btn_raw = (k <= 20) ? 5'b00001 : 5'b00000;
      @(posedge clk); #1;
      exp = {((k >= 6 && k <= 25) ? 5'b00001 : 5'b00000),
             ((k == 6)  ? 5'b00001 : 5'b00000),
             ((k == 26) ? 5'b00001 : 5'b00000),
             ((k == 16) ? 5'b00001 : 5'b00000)};
      got = {btn_level, btn_press, btn_release, btn_hold};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL clean_press edge=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  task automatic test_bounce();
    logic [7:0]  pat;
    logic [19:0] got;
    pat = 8'b0111_0111;  // applied LSB first: 1,1,1,0,1,1,1,0
    for (int k = 1; k <= 16; k++) begin
      btn_raw = (k <= 8) ? {3'b000, pat[k-1], 1'b0} : 5'b00000;
      @(posedge clk); #1;
      got = {btn_level, btn_press, btn_release, btn_hold};
      checks++;
      if (got !== 20'h0) begin
        errors++;
        $display("FAIL bounce_reject edge=%0d got=%h exp=00000", k, got);
      end
    end
  endtask

  task automatic test_short_press();
    logic [19:0] exp;
    logic [19:0] got;
    // 8-cycle press: release wins before the hold count completes.
    for (int k = 1; k <= 24; k++) begin
      btn_raw = (k <= 8) ? 5'b01000 : 5'b00000;
      @(posedge clk); #1;
      exp = {((k >= 6 && k <= 13) ? 5'b01000 : 5'b00000),
             ((k == 6)  ? 5'b01000 : 5'b00000),
             ((k == 14) ? 5'b01000 : 5'b00000),
             5'b00000};
      got = {btn_level, btn_press, btn_release, btn_hold};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL short_press edge=%0d got=%h exp=%h", k, got, exp);
      end
    end
    // Following long press gets a fresh hold count.
    for (int k = 1; k <= 30; k++) begin
      btn_raw = (k <= 20) ? 5'b01000 : 5'b00000;
      @(posedge clk); #1;
      exp = {((k >= 6 && k <= 25) ? 5'b01000 : 5'b00000),
             ((k == 6)  ? 5'b01000 : 5'b00000),
             ((k == 26) ? 5'b01000 : 5'b00000),
             ((k == 16) ? 5'b01000 : 5'b00000)};
      got = {btn_level, btn_press, btn_release, btn_hold};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL second_press edge=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [19:0] exp;
    logic [4:0]  lvl;
    logic [19:0] got;
    for (int k = 1; k <= 40; k++) begin
      if (k <= 20)      btn_raw = 5'b10101;
      else if (k <= 30) btn_raw = 5'b00101;
      else              btn_raw = 5'b00000;
      @(posedge clk); #1;
      if (k < 6)       lvl = 5'b00000;
      else if (k < 26) lvl = 5'b10101;
      else if (k < 36) lvl = 5'b00101;
      else             lvl = 5'b00000;
      exp = {lvl,
             ((k == 6)  ? 5'b10101 : 5'b00000),
             ((k == 26) ? 5'b10000 : ((k == 36) ? 5'b00101 : 5'b00000)),
             ((k == 16) ? 5'b10101 : 5'b00000)};
      got = {btn_level, btn_press, btn_release, btn_hold};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL simultaneous edge=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  task automatic test_mid_debounce_reset();
    logic [19:0] exp;
    logic [19:0] got;
    for (int k = 1; k <= 22; k++) begin
      btn_raw = (k <= 12) ? 5'b00100 : 5'b00000;
      rst_n   = (k == 4) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      exp = {((k >= 10 && k <= 17) ? 5'b00100 : 5'b00000),
             ((k == 10) ? 5'b00100 : 5'b00000),
             ((k == 18) ? 5'b00100 : 5'b00000),
             5'b00000};
      got = {btn_level, btn_press, btn_release, btn_hold};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL mid_debounce_reset edge=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    btn_raw = 5'b11111;
    test_reset();
    test_clean_press();
    test_bounce();
    test_short_press();
    test_simultaneous();
    test_mid_debounce_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
